// File: rtl/pc_next_unit.sv
// Program counter with next-PC select (seq/branch/jump/JR), boot cycle, stall and halt/resume FSM.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_4180
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_index,
  input  logic [31:0] rs_data,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] pc_updates,
  output logic        trap
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_TRAP = 2'b11
  } state_t;

  state_t      cur_state;
  logic [31:0] next_pc;

  // NOTE: next_pc gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = branch_taken ? pc_plus4 + (imm_ext << 2) : pc_plus4;
      2'b10: next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      2'b11: next_pc = rs_data;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= RESET_VECTOR;
      cur_state  <= ST_BOOT;
      pc_updates <= '0;
    end else begin
      unique case (cur_state)
        ST_BOOT: cur_state <= ST_RUN;
        ST_RUN: begin
          if (halt_req) begin
            cur_state <= ST_HALT;
          end else if (!stall) begin
            pc_updates <= pc_updates + 32'd1;
`ifdef PC_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              pc        <= TRAP_VECTOR;
              cur_state <= ST_TRAP;
            end else begin
              pc <= next_pc;
            end
`else
            pc <= next_pc & ~32'h3;
`endif
          end
        end
        ST_HALT: if (resume) cur_state <= ST_RUN;
        // pc already equals TRAP_VECTOR on entry, so reloading it is a hold.
        ST_TRAP: pc <= TRAP_VECTOR;
      endcase
    end
  end

  assign state  = cur_state;
  assign halted = (cur_state == ST_HALT);
`ifdef PC_MISALIGN_TRAP_EN
  assign trap   = (cur_state == ST_TRAP);
`else
  assign trap   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: expectations queued at drive time, compared after each posedge.
module tb_pc_next_unit;

  localparam logic [1:0] S_BOOT = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10, S_TRAP = 2'b11;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_src = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] imm_ext = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] rs_data = '0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] pc_updates;
  logic        trap;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  pc_next_unit dut (
    .CLK(CLK), .RST(RST), .pc_plus4(pc_plus4), .pc_src(pc_src),
    .branch_taken(branch_taken), .imm_ext(imm_ext), .jump_index(jump_index),
    .rs_data(rs_data), .stall(stall), .halt_req(halt_req), .resume(resume),
    .pc(pc), .state(state), .halted(halted), .pc_updates(pc_updates), .trap(trap)
  );

  // Adder model feeding back into the unit.
  assign pc_plus4 = pc + 32'd4;

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input logic rst, input logic [1:0] src,
                       input logic tk, input logic [31:0] imm, input logic [25:0] ji,
                       input logic [31:0] rs, input logic stl, input logic hr, input logic rsm,
                       input logic [31:0] e_pc, input logic [1:0] e_st, input logic [31:0] e_cnt);
    exp_t e;
    @(negedge CLK);
    RST = rst; pc_src = src; branch_taken = tk; imm_ext = imm; jump_index = ji;
    rs_data = rs; stall = stl; halt_req = hr; resume = rsm;
    e.tag = tag; e.pc = e_pc; e.st = e_st; e.cnt = e_cnt;
    q.push_back(e);
    @(posedge CLK);
  endtask

  task automatic seq(input string tag, input logic [31:0] e_pc, input logic [1:0] e_st,
                     input logic [31:0] e_cnt);
    drive(tag, 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, e_pc, e_st, e_cnt);
  endtask

  initial begin
    forever begin
      exp_t e;
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".pc"}, pc, e.pc);
        check({e.tag, ".state"}, {30'd0, state}, {30'd0, e.st});
        check({e.tag, ".cnt"}, pc_updates, e.cnt);
        check({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.st == S_HALT});
        check({e.tag, ".trap"}, {31'd0, trap}, {31'd0, e.st == S_TRAP});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    drive("reset", 1'b1, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 32'h3000, S_BOOT, 0);
    // Boot ignores halt_req and stall.
    drive("boot", 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 32'h3000, S_RUN, 0);
    seq("seq1", 32'h3004, S_RUN, 1);
    seq("seq2", 32'h3008, S_RUN, 2);
    drive("br_taken", 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFE, '0, '0, 1'b0, 1'b0, 1'b0, 32'h3004, S_RUN, 3);
    seq("seq3", 32'h3008, S_RUN, 4);
    drive("br_not", 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFE, '0, '0, 1'b0, 1'b0, 1'b0, 32'h300C, S_RUN, 5);
    drive("jump", 1'b0, 2'b10, 1'b0, '0, 26'h0000C40, '0, 1'b0, 1'b0, 1'b0, 32'h3100, S_RUN, 6);
    drive("jr", 1'b0, 2'b11, 1'b0, '0, '0, 32'h3200, 1'b0, 1'b0, 1'b0, 32'h3200, S_RUN, 7);
    for (int i = 0; i < 3; i++)
      drive("stall", 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 32'h3200, S_RUN, 7);
    drive("halt_over_stall", 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 32'h3200, S_HALT, 7);
    drive("halt_stall", 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 32'h3200, S_HALT, 7);
    drive("halt_hold", 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 32'h3200, S_HALT, 7);
    drive("resume_wins", 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, 32'h3200, S_RUN, 7);
    seq("post_resume", 32'h3204, S_RUN, 8);
    drive("halt2", 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 32'h3204, S_HALT, 8);
    drive("rst_halt", 1'b1, 2'b00, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1, 32'h3000, S_BOOT, 0);
    seq("boot2", 32'h3000, S_RUN, 0);
    drive("jr_top", 1'b0, 2'b11, 1'b0, '0, '0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, S_RUN, 1);
    seq("wrap", 32'h0000_0000, S_RUN, 2);
    drive("jr_start", 1'b0, 2'b11, 1'b0, '0, '0, 32'h3200, 1'b0, 1'b0, 1'b0, 32'h3200, S_RUN, 3);
`ifdef PC_MISALIGN_TRAP_EN
    drive("misalign", 1'b0, 2'b11, 1'b0, '0, '0, 32'h3202, 1'b0, 1'b0, 1'b0, 32'h4180, S_TRAP, 4);
    seq("trap_hold", 32'h4180, S_TRAP, 4);
    drive("trap_ign", 1'b0, 2'b11, 1'b0, '0, '0, 32'h3000, 1'b0, 1'b1, 1'b1, 32'h4180, S_TRAP, 4);
    drive("halt_over_trap", 1'b1, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 32'h3000, S_BOOT, 0);
    seq("boot3", 32'h3000, S_RUN, 0);
    drive("halt_pri", 1'b0, 2'b11, 1'b0, '0, '0, 32'h3202, 1'b0, 1'b1, 1'b0, 32'h3000, S_HALT, 0);
`else
    drive("misalign", 1'b0, 2'b11, 1'b0, '0, '0, 32'h3202, 1'b0, 1'b0, 1'b0, 32'h3200, S_RUN, 4);
    seq("after_mis", 32'h3204, S_RUN, 5);
`endif
    drive("rst_end", 1'b1, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 32'h3000, S_BOOT, 0);
    @(negedge CLK);
    check("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register plus next-PC selection for the single-cycle MIPS datapath.
- Sits directly upstream of the PC+4 adder:
  - drives the adder's input (`pc`);
  - consumes its output (`pc_plus4`);
  - selects the next PC from sequential, branch, jump or jump-register targets.
- Adds a boot cycle, stall, and a halt/resume state machine.

Parameters:
- RESET_VECTOR, 32'h0000_3000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_4180, PC loaded on misaligned target (optional feature only).

Ports:
- CLK  input  1  system clock; all state updates on posedge CLK.
- RST  input  1  synchronous, active-high reset.
- pc_plus4  input  32  PC+4 of current `pc`, from the adder; must be valid before posedge.
- pc_src  input  2  00 sequential, 01 branch, 10 jump (J/JAL), 11 jump-register.
- branch_taken  input  1  branch condition result; used only when pc_src=01.
- imm_ext  input  32  sign-extended 16-bit branch offset (word units).
- jump_index  input  26  instr[25:0] for J/JAL.
- rs_data  input  32  register value for JR.
- stall  input  1  hold PC this cycle.
- halt_req  input  1  enter HALT.
- resume  input  1  leave HALT.
- pc  output  32  current PC; drives the adder input and instruction memory address.
- state  output  2  00 BOOT, 01 RUN, 10 HALT, 11 TRAP.
- halted  output  1  high while state==HALT.
- pc_updates  output  32  count of cycles in which `pc` advanced in RUN.
- trap  output  1  high while state==TRAP (0 when feature compiled out).

Behaviour:
- Reset (RST=1 at posedge, overrides everything, including mid-HALT/TRAP/stall):
  - pc=RESET_VECTOR, state=BOOT, pc_updates=0, halted=0, trap=0.
- BOOT:
  - Lasts exactly one cycle; pc held; then RUN unconditionally.
  - halt_req and stall are ignored in BOOT.
- RUN, priority per posedge: halt_req > stall > update.
  - halt_req=1: state->HALT, pc held, no count.
  - stall=1: pc held, no count.
  - Otherwise pc<=next_pc and pc_updates++.
- next_pc (combinational):
  - pc_src=00: pc_plus4.
  - pc_src=01: branch_taken ? pc_plus4 + (imm_ext<<2) : pc_plus4.
  - pc_src=10: {pc_plus4[31:28], jump_index, 2'b00}.
  - pc_src=11: rs_data.
- Arithmetic: all 32-bit modulo 2^32; wrap silently (0xFFFF_FFFC + 4 -> 0).
- pc_updates wraps 0xFFFF_FFFF -> 0.
- HALT:
  - pc and counter frozen; halted=1.
  - resume=1 -> RUN next cycle; first update happens the cycle after that.
  - halt_req and resume both high in HALT: resume wins.
  - stall is ignored in HALT.
- Outputs are registered except `halted` and `trap`, which decode `state`.
- Latency: a selection presented in cycle N appears on `pc` after the posedge ending cycle N.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - In RUN, an update whose next_pc[1:0]!=0 loads pc=TRAP_VECTOR and state->TRAP, counted as an update.
  - halt_req still takes priority over the trap.
  - TRAP: pc held; trap=1; only RST exits.
- Undefined:
  - next_pc[1:0] is forced to 00 before loading.
  - TRAP is unreachable; trap tied 0.

Test Plan:
- Reset then sequential run, adder model pc+4:
  - cycle 1 state=BOOT, pc=0x3000;
  - then 0x3004, 0x3008; pc_updates=2.
- Branch at pc=0x3008 with pc_src=01, imm_ext=0xFFFF_FFFE:
  - taken=1 -> pc=0x3004;
  - taken=0 -> 0x300C.
- Jump and JR:
  - pc=0x3000, jump_index=0x0000C40 -> pc=0x0000_3100;
  - pc_src=11, rs_data=0x0000_3200 -> pc=0x3200.
- Stall/halt:
  - stall=1 for 3 cycles -> pc and pc_updates frozen;
  - halt_req=1 -> halted=1, state=10;
  - halt_req+resume together -> RUN next cycle, update the cycle after.
- Reset mid-HALT:
  - RST=1 -> pc=0x3000, state=BOOT, counter=0 at next posedge.
- Wrap and feature:
  - pc_src=11, rs_data=0xFFFF_FFFC, then sequential -> pc=0x0000_0000.
  - With PC_MISALIGN_TRAP_EN, rs_data=0x3202 -> pc=0x4180, trap=1, held until RST.
  - Without it, same stimulus -> pc=0x3200.
